// File: rtl/axis_i2c_cmd_seq.sv
// axis_i2c_cmd_seq: parses a 32-bit AXI-Stream command stream into I2C
// transactions, queues them, issues them to the single-master engine and
// returns masked, tagged read data on a response stream.
module axis_i2c_cmd_seq #(
  parameter int BUS_COUNT = 1,
  parameter int BUS_BITS  = (BUS_COUNT == 1) ? 1 : $clog2(BUS_COUNT),
  parameter int CMD_DEPTH = 8,
  parameter int CNT_BITS  = $clog2(CMD_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         s_cmd_data,
  input  logic                s_cmd_valid,
  output logic                s_cmd_ready,
  output logic [BUS_BITS-1:0] m_i2c_busno,
  output logic [2:0]          m_i2c_wrlen,
  output logic [2:0]          m_i2c_rdlen,
  output logic [6:0]          m_i2c_addr,
  output logic [31:0]         m_i2c_data,
  output logic                m_i2c_valid,
  input  logic                m_i2c_ready,
  input  logic [31:0]         s_rx_data,
  input  logic                s_rx_valid,
  output logic                s_rx_ready,
  output logic [31:0]         m_rsp_data,
  output logic [7:0]          m_rsp_tag,
  output logic                m_rsp_valid,
  input  logic                m_rsp_ready,
  output logic [CNT_BITS-1:0] cmd_pending,
  output logic                cmd_err
);
  localparam int PTR_BITS = $clog2(CMD_DEPTH);

  typedef struct packed {
    logic [7:0]          tag;
    logic [BUS_BITS-1:0] busno;
    logic [2:0]          wrlen;
    logic [2:0]          rdlen;
    logic [6:0]          addr;
    logic [31:0]         data;
  } cmd_t;

  typedef enum logic {HDR, DATA} pstate_t;

  pstate_t             state;
  cmd_t                hdr_q, hdr_dec, push_cmd, head, iss;
  cmd_t                mem [CMD_DEPTH];
  logic [PTR_BITS-1:0] wr_ptr, rd_ptr;
  logic [CNT_BITS-1:0] count;
  logic                fifo_full, fifo_empty, push, pop;
  logic                beat_acc, hdr_bad, hdr_long;
  logic                rd_outstanding, rd_block, i2c_acc, rx_acc;
  logic [7:0]          lat_tag;
  logic [2:0]          lat_rdlen;
  logic [31:0]         rx_mask;

  // Header decode straight off the stream
  always_comb begin
    hdr_dec       = '0;
    hdr_dec.tag   = s_cmd_data[31:24];
    hdr_dec.busno = s_cmd_data[16 +: BUS_BITS];
    hdr_dec.wrlen = s_cmd_data[10:8];
    hdr_dec.rdlen = s_cmd_data[14:12];
    hdr_dec.addr  = s_cmd_data[6:0];
  end

  assign hdr_bad  = (hdr_dec.wrlen > 3'd4) || (hdr_dec.rdlen > 3'd4) ||
                    (hdr_dec.wrlen == 3'd0 && hdr_dec.rdlen == 3'd0) ||
                    (int'(s_cmd_data[19:16]) >= BUS_COUNT);
  // Headers that push nothing this beat (dropped, or waiting for data)
  // can be taken even when the FIFO is full.
  assign hdr_long = !hdr_bad && (hdr_dec.wrlen != 3'd0);

  assign fifo_full   = (count == CNT_BITS'(CMD_DEPTH));
  assign fifo_empty  = (count == '0);
  assign cmd_pending = count;

  // Command-stream ready; held low through reset
  always_comb begin
    s_cmd_ready = 1'b0;
    if (!rst) begin
      if (state == HDR) s_cmd_ready = !fifo_full || hdr_bad || hdr_long;
      else              s_cmd_ready = !fifo_full;
    end
  end

  assign beat_acc = s_cmd_valid && s_cmd_ready;
  assign push     = beat_acc && ((state == DATA) || (!hdr_bad && !hdr_long));

  // Entry to enqueue: header-only commands carry a zero payload
  always_comb begin
    push_cmd = hdr_dec;
    if (state == DATA) begin
      push_cmd      = hdr_q;
      push_cmd.data = s_cmd_data;
    end
  end

  // Parser FSM: header latch and malformed-header pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= HDR;
      hdr_q   <= '0;
      cmd_err <= 1'b0;
    end else begin
      cmd_err <= beat_acc && (state == HDR) && hdr_bad;
      if (beat_acc) begin
        case (state)
          HDR: if (hdr_long) begin
            hdr_q <= hdr_dec;
            state <= DATA;
          end
          DATA: state <= HDR;
          default: state <= HDR;
        endcase
      end
    end
  end

  // FIFO storage; contents need no reset since occupancy gates reads
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_cmd;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head    = mem[rd_ptr];
  assign i2c_acc = m_i2c_valid && m_i2c_ready;
  assign rx_acc  = s_rx_valid && s_rx_ready;
  // A read in the issue register, accepted or not, also blocks the next read
  assign rd_block = rd_outstanding || (m_i2c_valid && iss.rdlen != 3'd0);
  assign pop = !fifo_empty && (!m_i2c_valid || m_i2c_ready) &&
               !(head.rdlen != 3'd0 && rd_block);

  // Issue register toward the master, read tracking and tag latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss            <= '0;
      m_i2c_valid    <= 1'b0;
      rd_outstanding <= 1'b0;
      lat_tag        <= '0;
      lat_rdlen      <= '0;
    end else begin
      if (pop) begin
        iss         <= head;
        m_i2c_valid <= 1'b1;
      end else if (m_i2c_ready) begin
        m_i2c_valid <= 1'b0;
      end
      if (i2c_acc && iss.rdlen != 3'd0) begin
        rd_outstanding <= 1'b1;
        lat_tag        <= iss.tag;
        lat_rdlen      <= iss.rdlen;
      end else if (rx_acc) begin
        rd_outstanding <= 1'b0;
      end
    end
  end

  assign m_i2c_busno = iss.busno;
  assign m_i2c_wrlen = iss.wrlen;
  assign m_i2c_rdlen = iss.rdlen;
  assign m_i2c_addr  = iss.addr;
  assign m_i2c_data  = iss.data;

  // Keep only the bytes actually read; rdlen 4 passes the whole word
  always_comb begin
    case (lat_rdlen)
      3'd1:    rx_mask = 32'h0000_00FF;
      3'd2:    rx_mask = 32'h0000_FFFF;
      3'd3:    rx_mask = 32'h00FF_FFFF;
      3'd4:    rx_mask = 32'hFFFF_FFFF;
      default: rx_mask = 32'h0000_0000;
    endcase
  end

  assign s_rx_ready = !rst && !m_rsp_valid;

  // Response holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rsp_valid <= 1'b0;
      m_rsp_data  <= '0;
      m_rsp_tag   <= '0;
    end else if (rx_acc) begin
      m_rsp_valid <= 1'b1;
      m_rsp_data  <= s_rx_data & rx_mask;
      m_rsp_tag   <= lat_tag;
    end else if (m_rsp_ready) begin
      m_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_i2c_cmd_seq.sv
// tb_axis_i2c_cmd_seq: table of command vectors plus hand sequences for
// stall, back-pressure and reset; issue and response scoreboards.
module tb_axis_i2c_cmd_seq;
  localparam int DEPTH = 4;
  localparam int CNT   = $clog2(DEPTH) + 1;

  logic           clk = 1'b0, rst = 1'b1;
  logic [31:0]    s_cmd_data = '0;
  logic           s_cmd_valid = 1'b0, s_cmd_ready;
  logic [0:0]     m_i2c_busno;
  logic [2:0]     m_i2c_wrlen, m_i2c_rdlen;
  logic [6:0]     m_i2c_addr;
  logic [31:0]    m_i2c_data;
  logic           m_i2c_valid, m_i2c_ready = 1'b1;
  logic [31:0]    s_rx_data = '0;
  logic           s_rx_valid = 1'b0, s_rx_ready;
  logic [31:0]    m_rsp_data;
  logic [7:0]     m_rsp_tag;
  logic           m_rsp_valid, m_rsp_ready = 1'b1;
  logic [CNT-1:0] cmd_pending;
  logic           cmd_err;

  axis_i2c_cmd_seq #(.BUS_COUNT(2), .CMD_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_cmd_data(s_cmd_data), .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .m_i2c_busno(m_i2c_busno), .m_i2c_wrlen(m_i2c_wrlen), .m_i2c_rdlen(m_i2c_rdlen),
    .m_i2c_addr(m_i2c_addr), .m_i2c_data(m_i2c_data), .m_i2c_valid(m_i2c_valid),
    .m_i2c_ready(m_i2c_ready),
    .s_rx_data(s_rx_data), .s_rx_valid(s_rx_valid), .s_rx_ready(s_rx_ready),
    .m_rsp_data(m_rsp_data), .m_rsp_tag(m_rsp_tag), .m_rsp_valid(m_rsp_valid),
    .m_rsp_ready(m_rsp_ready),
    .cmd_pending(cmd_pending), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hdr;
    logic [31:0] dat;
    logic        bad;
    logic [0:0]  busno;
    logic [2:0]  wl;
    logic [2:0]  rl;
    logic [6:0]  addr;
    logic [7:0]  tag;
  } vec_t;

  typedef struct {
    logic [0:0]  busno;
    logic [2:0]  wl;
    logic [2:0]  rl;
    logic [6:0]  addr;
    logic [31:0] data;
    logic [7:0]  tag;
  } iss_t;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  tag;
  } rsp_t;

  iss_t        exp_iss[$];
  rsp_t        exp_rsp[$];
  logic [31:0] rx_q[$];
  logic [31:0] rx_pre[$];
  int          checks = 0, errors = 0;
  logic        rx_fire = 1'b0, model_rd_out = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] rmask(input logic [31:0] d, input logic [2:0] rl);
    logic [31:0] m;
    m = 32'hFFFF_FFFF;
    if (rl < 3'd4) m = (32'd1 << (8 * rl)) - 32'd1;
    return d & m;
  endfunction

  function automatic iss_t mk_iss(input logic [0:0] b, input logic [2:0] wl,
                                  input logic [2:0] rl, input logic [6:0] a,
                                  input logic [31:0] d, input logic [7:0] t);
    iss_t e;
    e.busno = b; e.wl = wl; e.rl = rl; e.addr = a; e.data = d; e.tag = t;
    return e;
  endfunction

  // Master model: answers each accepted read with one rx word
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_rx_valid = 1'b0;
      s_rx_data  = '0;
      rx_q.delete();
    end else begin
      #1;
      if (rx_fire) s_rx_valid = 1'b0;
      if (!s_rx_valid && rx_q.size() > 0) begin
        s_rx_data  = rx_q.pop_front();
        s_rx_valid = 1'b1;
      end
    end
  end

  // Monitor: handshakes seen at negedge complete at the next posedge
  always @(negedge clk) begin
    iss_t        e;
    rsp_t        r;
    logic [31:0] w;
    if (rst) begin
      rx_fire      = 1'b0;
      model_rd_out = 1'b0;
    end else begin
      rx_fire = s_rx_valid && s_rx_ready;
      if (rx_fire) model_rd_out = 1'b0;
      if (m_i2c_valid && m_i2c_rdlen != 3'd0) chk("one_read", 32'(model_rd_out), 32'd0);
      if (m_i2c_valid && m_i2c_ready) begin
        checks++;
        if (exp_iss.size() == 0) begin
          errors++;
          $display("FAIL iss_unexpected at %0t: got addr %0h want none", $time, m_i2c_addr);
        end else begin
          e = exp_iss.pop_front();
          chk("iss_addr",  32'(m_i2c_addr),  32'(e.addr));
          chk("iss_wrlen", 32'(m_i2c_wrlen), 32'(e.wl));
          chk("iss_rdlen", 32'(m_i2c_rdlen), 32'(e.rl));
          chk("iss_busno", 32'(m_i2c_busno), 32'(e.busno));
          chk("iss_data",  m_i2c_data,       e.data);
          if (e.rl != 3'd0) begin
            w = (rx_pre.size() > 0) ? rx_pre.pop_front() : $urandom;
            rx_q.push_back(w);
            r.data = rmask(w, e.rl);
            r.tag  = e.tag;
            exp_rsp.push_back(r);
            model_rd_out = 1'b1;
          end
        end
      end
      if (m_rsp_valid && m_rsp_ready) begin
        checks++;
        if (exp_rsp.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected at %0t: got tag %0h want none", $time, m_rsp_tag);
        end else begin
          r = exp_rsp.pop_front();
          chk("rsp_data", m_rsp_data, r.data);
          chk("rsp_tag",  32'(m_rsp_tag), 32'(r.tag));
        end
      end
    end
  end

  // Present one beat and hold it until accepted (caller sits at posedge+1)
  task automatic send(input logic [31:0] d);
    int n;
    n = 0;
    s_cmd_data  = d;
    s_cmd_valid = 1'b1;
    @(negedge clk);
    while (!s_cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_cmd_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout at %0t: got ready 0 want 1 for %0h", $time, d);
    end
    @(posedge clk); #1;
    s_cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_iss.size() != 0 || exp_rsp.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(exp_iss.size() + exp_rsp.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  vec_t vt[9];

  initial begin
    int n;
    vt[0] = '{32'h0000_0250, 32'h0000_BEEF, 1'b0, 1'b0, 3'd2, 3'd0, 7'h50, 8'h00};
    vt[1] = '{32'h5A00_3048, 32'h0,         1'b0, 1'b0, 3'd0, 3'd3, 7'h48, 8'h5A};
    vt[2] = '{32'h0000_0550, 32'hDEAD_0001, 1'b1, 1'b0, 3'd0, 3'd0, 7'h00, 8'h00};
    vt[3] = '{32'h1100_1021, 32'h0,         1'b0, 1'b0, 3'd0, 3'd1, 7'h21, 8'h11};
    vt[4] = '{32'h0000_5010, 32'h0,         1'b1, 1'b0, 3'd0, 3'd0, 7'h00, 8'h00};
    vt[5] = '{32'h0000_0033, 32'h0,         1'b1, 1'b0, 3'd0, 3'd0, 7'h00, 8'h00};
    vt[6] = '{32'h0002_1010, 32'h0,         1'b1, 1'b0, 3'd0, 3'd0, 7'h00, 8'h00};
    vt[7] = '{32'h7E01_4477, 32'h1234_5678, 1'b0, 1'b1, 3'd4, 3'd4, 7'h77, 8'h7E};
    vt[8] = '{32'h33F0_8180, 32'h0000_00A5, 1'b0, 1'b0, 3'd1, 3'd0, 7'h00, 8'h33};

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_cmd_ready", 32'(s_cmd_ready), 32'd0);
    chk("rst_i2c_valid", 32'(m_i2c_valid), 32'd0);
    chk("rst_rx_ready",  32'(s_rx_ready),  32'd0);
    chk("rst_rsp_valid", 32'(m_rsp_valid), 32'd0);
    chk("rst_cmd_err",   32'(cmd_err),     32'd0);
    chk("rst_rsp_data",  m_rsp_data,       32'd0);
    chk("rst_rsp_tag",   32'(m_rsp_tag),   32'd0);
    chk("rst_pending",   32'(cmd_pending), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Header-only read into an empty FIFO: valid two cycles after the beat
    exp_iss.push_back(mk_iss(1'b0, 3'd0, 3'd2, 7'h05, 32'h0, 8'h66));
    send(32'h6600_2005);
    @(negedge clk);
    chk("lat_valid_early", 32'(m_i2c_valid), 32'd0);
    chk("lat_pending",     32'(cmd_pending), 32'd1);
    @(negedge clk);
    chk("lat_valid", 32'(m_i2c_valid), 32'd1);
    @(posedge clk); #1;
    drain();

    // Vector table
    rx_pre.push_back(32'hFFAA_BBCC);
    for (int i = 0; i < 9; i++) begin
      if (vt[i].bad) begin
        send(vt[i].hdr);
        @(negedge clk);
        chk($sformatf("err_pulse_%0d", i), 32'(cmd_err), 32'd1);
        @(negedge clk);
        chk($sformatf("err_clear_%0d", i), 32'(cmd_err), 32'd0);
        @(posedge clk); #1;
      end else begin
        exp_iss.push_back(mk_iss(vt[i].busno, vt[i].wl, vt[i].rl, vt[i].addr,
                                 (vt[i].wl != 3'd0) ? vt[i].dat : 32'h0, vt[i].tag));
        send(vt[i].hdr);
        if (vt[i].wl != 3'd0) send(vt[i].dat);
      end
    end
    drain();

    // Fill and stall
    m_i2c_ready = 1'b0;
    for (int k = 0; k < DEPTH + 2; k++)
      exp_iss.push_back(mk_iss(1'b0, 3'd0, 3'd1, 7'(k), 32'h0, 8'(8'h20 + k)));
    for (int k = 0; k < DEPTH + 1; k++)
      send(32'h2000_1000 + (k << 24) + k);
    s_cmd_data  = 32'h2500_1005;
    s_cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("stall_ready",   32'(s_cmd_ready), 32'd0);
    chk("stall_pending", 32'(cmd_pending), 32'(DEPTH));
    chk("stall_hold",    32'(m_i2c_valid), 32'd1);
    chk("stall_head",    32'(m_i2c_addr),  32'd0);
    @(posedge clk); #1;
    m_i2c_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_release", 32'(s_cmd_ready), 32'd1);
    @(posedge clk); #1;
    s_cmd_valid = 1'b0;
    drain();

    // Response back-pressure
    m_rsp_ready = 1'b0;
    exp_iss.push_back(mk_iss(1'b0, 3'd0, 3'd2, 7'h31, 32'h0, 8'hB1));
    exp_iss.push_back(mk_iss(1'b0, 3'd0, 3'd4, 7'h32, 32'h0, 8'hB2));
    send(32'hB100_2031);
    send(32'hB200_4032);
    repeat (20) @(negedge clk);
    chk("bp_rsp_valid", 32'(m_rsp_valid), 32'd1);
    chk("bp_rsp_tag",   32'(m_rsp_tag),   32'hB1);
    chk("bp_rx_valid",  32'(s_rx_valid),  32'd1);
    chk("bp_rx_ready",  32'(s_rx_ready),  32'd0);
    @(posedge clk); #1;
    m_rsp_ready = 1'b1;
    drain();

    // Async reset while in DATA with three entries queued
    m_i2c_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(32'hC000_1000 + (k << 24) + k);
    send(32'h0000_0260);
    @(negedge clk);
    chk("pre_rst_pending", 32'(cmd_pending), 32'd3);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_cmd_ready", 32'(s_cmd_ready), 32'd0);
    chk("arst_i2c_valid", 32'(m_i2c_valid), 32'd0);
    chk("arst_pending",   32'(cmd_pending), 32'd0);
    chk("arst_rx_ready",  32'(s_rx_ready),  32'd0);
    chk("arst_rsp_valid", 32'(m_rsp_valid), 32'd0);
    exp_iss.delete();
    exp_rsp.delete();
    rx_pre.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    m_i2c_ready = 1'b1;
    exp_iss.push_back(mk_iss(1'b0, 3'd0, 3'd1, 7'h11, 32'h0, 8'h42));
    send(32'h4200_1011);
    drain();
    @(negedge clk);
    chk("end_pending", 32'(cmd_pending), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
